// File: rtl/tb_sim_ctrl_pkg.sv
// Shared types and default constants for the simulation run controller.
// The state enum and the defaults are used by the top and by the reset sequencer.
package tb_sim_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_NUM_RST      = 2;
  localparam int DEF_RST_CYCLES   = 10;
  localparam int DEF_RST_STAGGER  = 2;
  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_CNT_W        = 64;
  localparam int DEF_EXIT_W       = 32;

  // Width of the reset-sequence and drain counters.
  localparam int SEQ_W = 16;

endpackage

// File: rtl/tb_rst_stagger.sv
// Staggered reset release: a free-running sequence counter plus one sticky
// release register per channel, set when the counter hits that channel's slot.
module tb_rst_stagger
  import tb_sim_ctrl_pkg::*;
#(
  parameter int NUM_RST     = DEF_NUM_RST,
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int RST_STAGGER = DEF_RST_STAGGER
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               clr_i,
  output logic [NUM_RST-1:0] rel_o
);

  logic [SEQ_W-1:0]   seq_q;
  logic [NUM_RST-1:0] hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seq_q <= '0;
    end else if (en_i && !(&seq_q)) begin
      seq_q <= seq_q + SEQ_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_RST; k++) begin : g_ch
    localparam logic [SEQ_W-1:0] REL_AT = SEQ_W'(RST_CYCLES + k * RST_STAGGER);
    assign hit[k] = (seq_q == REL_AT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rel_o <= '0;
    end else if (clr_i) begin
      rel_o <= '0;
    end else if (en_i) begin
      rel_o <= rel_o | hit;
    end
  end

endmodule

// File: rtl/tb_sim_ctrl.sv
// Simulation run controller: sequences DUT resets, counts run cycles against a
// budget, captures the DUT exit code, drains, then flags done/pass.
module tb_sim_ctrl
  import tb_sim_ctrl_pkg::*;
#(
  parameter int NUM_RST      = DEF_NUM_RST,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int RST_STAGGER  = DEF_RST_STAGGER,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int EXIT_W       = DEF_EXIT_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [CNT_W-1:0]   num_cycles_i,
  input  logic               exit_valid_i,
  input  logic [EXIT_W-1:0]  exit_value_i,
  output logic [NUM_RST-1:0] dut_rst_no,
  output logic               running_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic               pass_o,
  output logic [EXIT_W-1:0]  exit_code_o,
  output logic [CNT_W-1:0]   cycle_cnt_o
);

  if (NUM_RST < 1 || NUM_RST > 8) begin : g_bad_num_rst
    $error("tb_sim_ctrl: NUM_RST must be in 1..8");
  end
  if (CNT_W < 16) begin : g_bad_cnt_w
    $error("tb_sim_ctrl: CNT_W must be at least 16");
  end

  state_e             state_q, state_d, end_st;
  logic [CNT_W-1:0]   lim_q, lim_d, cnt_d, cnt_inc;
  logic [SEQ_W-1:0]   drain_q, drain_d;
  logic [EXIT_W-1:0]  code_d;
  logic               tmo_d;
  logic [NUM_RST-1:0] rel;

  tb_rst_stagger #(
    .NUM_RST     (NUM_RST),
    .RST_CYCLES  (RST_CYCLES),
    .RST_STAGGER (RST_STAGGER)
  ) u_stagger (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (state_q == ST_RESET),
    .clr_i  (state_d == ST_DONE),
    .rel_o  (rel)
  );

  assign dut_rst_no = rel;

  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    cnt_d   = cycle_cnt_o;
    drain_d = drain_q;
    code_d  = exit_code_o;
    tmo_d   = timeout_o;
    cnt_inc = (&cycle_cnt_o) ? cycle_cnt_o : cycle_cnt_o + CNT_W'(1);
    end_st  = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
    case (state_q)
      ST_RESET: begin
        if (rel[NUM_RST-1]) begin
          state_d = ST_RUN;
          lim_d   = num_cycles_i;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d   = cnt_inc;
        drain_d = '0;
        // Exit takes priority over a budget expiring on the same edge.
        if (exit_valid_i) begin
          code_d  = exit_value_i;
          state_d = end_st;
        end else if (lim_q != '0 && cnt_inc == lim_q) begin
          tmo_d   = 1'b1;
          state_d = end_st;
        end
      end
      ST_DRAIN: begin
        if (drain_q == SEQ_W'(DRAIN_CYCLES - 1)) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + SEQ_W'(1);
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RESET;
      lim_q       <= '0;
      drain_q     <= '0;
      cycle_cnt_o <= '0;
      exit_code_o <= '0;
      timeout_o   <= 1'b0;
      running_o   <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lim_q       <= lim_d;
      drain_q     <= drain_d;
      cycle_cnt_o <= cnt_d;
      exit_code_o <= code_d;
      timeout_o   <= tmo_d;
      running_o   <= (state_d == ST_RUN);
      done_o      <= (state_d == ST_DONE);
      pass_o      <= (state_d == ST_DONE) && !tmo_d && (code_d == '0);
    end
  end

endmodule

// File: tb/tb_tb_sim_ctrl.sv
// Self-checking bench for tb_sim_ctrl: a default instance plus a 4-channel,
// zero-stagger, zero-drain instance, driven by directed and random runs.
module tb_tb_sim_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic [63:0] ncyc  [2];
  logic        exv   [2];
  logic [31:0] exval [2];
  logic [7:0]  drst  [2];
  logic        run   [2];
  logic        done  [2];
  logic        tmo   [2];
  logic        pass  [2];
  logic [31:0] code  [2];
  logic [63:0] cnt   [2];

  logic [1:0]  drst_a;
  logic [3:0]  drst_b;
  logic [15:0] cnt_b;

  assign drst[0] = {6'b0, drst_a};
  assign drst[1] = {4'b0, drst_b};
  assign cnt[1]  = {48'b0, cnt_b};

  tb_sim_ctrl u_dut_a (
    .clk_i        (clk),
    .rst_ni       (rst_n[0]),
    .num_cycles_i (ncyc[0]),
    .exit_valid_i (exv[0]),
    .exit_value_i (exval[0]),
    .dut_rst_no   (drst_a),
    .running_o    (run[0]),
    .done_o       (done[0]),
    .timeout_o    (tmo[0]),
    .pass_o       (pass[0]),
    .exit_code_o  (code[0]),
    .cycle_cnt_o  (cnt[0])
  );

  tb_sim_ctrl #(
    .NUM_RST      (4),
    .RST_STAGGER  (0),
    .DRAIN_CYCLES (0),
    .CNT_W        (16)
  ) u_dut_b (
    .clk_i        (clk),
    .rst_ni       (rst_n[1]),
    .num_cycles_i (ncyc[1][15:0]),
    .exit_valid_i (exv[1]),
    .exit_value_i (exval[1]),
    .dut_rst_no   (drst_b),
    .running_o    (run[1]),
    .done_o       (done[1]),
    .timeout_o    (tmo[1]),
    .pass_o       (pass[1]),
    .exit_code_o  (code[1]),
    .cycle_cnt_o  (cnt_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int p_nrst(input int i);  return (i == 0) ? 2 : 4; endfunction
  function automatic int p_stag(input int i);  return (i == 0) ? 2 : 0; endfunction
  function automatic int p_drain(input int i); return (i == 0) ? 4 : 0; endfunction
  localparam int P_CYC = 10;

  task automatic chk_all_zero(input string pfx, input int i);
    chk({pfx, "_dutrst"}, 64'(drst[i]), 64'd0);
    chk({pfx, "_run"},    64'(run[i]),  64'd0);
    chk({pfx, "_done"},   64'(done[i]), 64'd0);
    chk({pfx, "_tmo"},    64'(tmo[i]),  64'd0);
    chk({pfx, "_pass"},   64'(pass[i]), 64'd0);
    chk({pfx, "_code"},   64'(code[i]), 64'd0);
    chk({pfx, "_cnt"},    cnt[i],       64'd0);
  endtask

  // One full run: reset, staggered release, RUN until exit/budget, drain, done.
  // exit_at < 0 means no exit strobe; abort pulls reset mid-drain and returns.
  task automatic run_case(input int i, input logic [63:0] lim, input int exit_at,
                          input logic [31:0] xval, input bit abort);
    int     nr, tl, dr;
    longint ex, lm, e_end;
    bit     to_exp;
    logic [7:0] mask, all_ch;

    nr = p_nrst(i);
    dr = p_drain(i);
    tl = P_CYC + (nr - 1) * p_stag(i);
    all_ch = 8'((1 << nr) - 1);

    @(negedge clk);
    rst_n[i] = 1'b0;
    exv[i]   = 1'b0;
    #1;
    chk_all_zero("reset", i);
    ncyc[i] = lim;
    @(negedge clk);
    rst_n[i] = 1'b1;

    // Release edge e=0 is the first rising edge after rst_ni goes high.
    for (int e = 0; e <= tl + 1; e++) begin
      exv[i]   = 1'($urandom_range(0, 1));
      exval[i] = $urandom;
      @(negedge clk);
      mask = '0;
      for (int k = 0; k < nr; k++)
        if (e >= P_CYC + k * p_stag(i)) mask[k] = 1'b1;
      chk("seq_rel",  64'(drst[i]), 64'(mask));
      chk("seq_run",  64'(run[i]),  64'(e >= tl + 1));
      chk("seq_cnt",  cnt[i],       64'd0);
      chk("seq_done", 64'(done[i]), 64'd0);
    end

    ex     = (exit_at >= 0) ? longint'(exit_at + 1) : 64'd1 << 30;
    lm     = (lim != 0) ? longint'(lim) : 64'd1 << 30;
    e_end  = (ex <= lm) ? ex : lm;
    to_exp = (lm < ex);

    for (int r = 1; r <= e_end + dr + 3; r++) begin
      if (exit_at >= 0 && r == exit_at + 1) begin
        exv[i]   = 1'b1;
        exval[i] = xval;
      end else if (r > e_end) begin
        exv[i]   = 1'($urandom_range(0, 1));
        exval[i] = $urandom | 32'h1;
      end else begin
        exv[i]   = 1'b0;
        exval[i] = $urandom;
      end
      @(negedge clk);
      chk("run_cnt",  cnt[i],       64'((r < e_end) ? r : e_end));
      chk("run_run",  64'(run[i]),  64'(r < e_end));
      chk("run_done", 64'(done[i]), 64'(r >= e_end + dr));
      chk("run_tmo",  64'(tmo[i]),  64'(r >= e_end && to_exp));
      chk("run_code", 64'(code[i]), 64'((r >= e_end && !to_exp) ? xval : 32'd0));
      chk("run_pass", 64'(pass[i]), 64'(r >= e_end + dr && !to_exp && xval == 0));
      chk("run_rst",  64'(drst[i]), 64'((r >= e_end + dr) ? 8'd0 : all_ch));
      if (abort && r == e_end + 2) begin
        rst_n[i] = 1'b0;
        #1;
        chk_all_zero("abort", i);
        break;
      end
    end
    exv[i] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sel, ea;
    logic [63:0] lim;
    logic [31:0] xv;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      ncyc[i]  = '0;
      exv[i]   = 1'b0;
      exval[i] = '0;
    end
    repeat (3) @(negedge clk);

    run_case(0, 64'd100, -1, 32'd0,   1'b0);
    run_case(0, 64'd0,   37, 32'd0,   1'b0);
    run_case(0, 64'd50,  49, 32'h5,   1'b0);
    run_case(0, 64'd1,   -1, 32'd0,   1'b0);
    run_case(0, 64'd0,    0, 32'h7,   1'b0);
    run_case(0, 64'd30,  -1, 32'd0,   1'b1);
    run_case(0, 64'd0,   20, 32'd0,   1'b0);
    run_case(1, 64'd0,    5, 32'd0,   1'b0);
    run_case(1, 64'd3,   -1, 32'd0,   1'b0);
    run_case(1, 64'd9,    8, 32'hA5,  1'b0);

    for (int n = 0; n < 14; n++) begin
      sel = $urandom_range(0, 2);
      xv  = ($urandom_range(0, 2) == 0) ? $urandom : 32'd0;
      case (sel)
        0:       begin lim = 64'd0;                    ea = $urandom_range(0, 80); end
        1:       begin lim = 64'($urandom_range(1, 80)); ea = -1;                  end
        default: begin lim = 64'($urandom_range(1, 80)); ea = $urandom_range(0, 80); end
      endcase
      run_case((n % 4 == 3) ? 1 : 0, lim, ea, xv, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
